// File: rtl/output_spike_decoder.sv
// Rate-code output decoder: counts per-class spikes over one inference window,
// then scans the counters one class per cycle to pick the winner.
module output_spike_decoder #(
  parameter int OUTPUT_SIZE  = 10,
  parameter int SPIKE_WINDOW = 16,
  parameter int CNT_W        = $clog2(SPIKE_WINDOW + 1),
  parameter int IDX_W        = $clog2(OUTPUT_SIZE)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   step_valid,
  input  logic [OUTPUT_SIZE-1:0] spikes_in,
  output logic                   busy,
  output logic                   result_valid,
  output logic [IDX_W-1:0]       result_class,
  output logic [CNT_W-1:0]       result_count,
  output logic                   result_tie,
  output logic                   result_none,
  input  logic [IDX_W-1:0]       count_sel,
  output logic [CNT_W-1:0]       count_out
);

  // Handshake: start is only honoured in IDLE, step_valid only in ACCUM;
  // result_valid is a one-cycle strobe with no backpressure, results hold after it.
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ARGMAX, S_DONE} state_t;

  localparam logic [IDX_W:0] NUM_CLS = (IDX_W + 1)'(OUTPUT_SIZE);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt [OUTPUT_SIZE];
  logic [CNT_W-1:0] step_cnt;
  logic [IDX_W-1:0] scan_idx;
  logic [CNT_W-1:0] best_cnt, best_cnt_nxt;
  logic [IDX_W-1:0] best_idx, best_idx_nxt;
  logic             best_tie, best_tie_nxt;
  logic [CNT_W-1:0] cur_cnt;
  logic             last_step, last_scan;

  assign last_step = (step_cnt == CNT_W'(SPIKE_WINDOW - 1));
  assign last_scan = (scan_idx == IDX_W'(OUTPUT_SIZE - 1));
  assign busy      = (state != S_IDLE);
  assign cur_cnt   = cnt[scan_idx];
  assign count_out = ({1'b0, count_sel} < NUM_CLS) ? cnt[count_sel] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:   if (start) state_next = S_ACCUM;
      S_ACCUM:  if (step_valid && last_step) state_next = S_ARGMAX;
      S_ARGMAX: if (last_scan) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Strict greater-than keeps the lowest index on ties; an equal count at a
  // later index only raises the tie flag.
  always_comb begin
    best_cnt_nxt = best_cnt;
    best_idx_nxt = best_idx;
    best_tie_nxt = best_tie;
    if (cur_cnt > best_cnt) begin
      best_cnt_nxt = cur_cnt;
      best_idx_nxt = scan_idx;
      best_tie_nxt = 1'b0;
    end else if ((cur_cnt == best_cnt) && (scan_idx != '0)) begin
      best_tie_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= '0;
      step_cnt     <= '0;
      scan_idx     <= '0;
      best_cnt     <= '0;
      best_idx     <= '0;
      best_tie     <= 1'b0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_count <= '0;
      result_tie   <= 1'b0;
      result_none  <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= '0;
            step_cnt <= '0;
          end
        end
        S_ACCUM: begin
          if (step_valid) begin
            for (int i = 0; i < OUTPUT_SIZE; i++) cnt[i] <= cnt[i] + CNT_W'(spikes_in[i]);
            step_cnt <= step_cnt + 1'b1;
            scan_idx <= '0;
            best_cnt <= '0;
            best_idx <= '0;
            best_tie <= 1'b0;
          end
        end
        S_ARGMAX: begin
          best_cnt <= best_cnt_nxt;
          best_idx <= best_idx_nxt;
          best_tie <= best_tie_nxt;
          scan_idx <= scan_idx + 1'b1;
          // Results are captured on entry to DONE so they are visible with the strobe.
          if (last_scan) begin
            result_valid <= 1'b1;
            result_class <= best_idx_nxt;
            result_count <= best_cnt_nxt;
            result_tie   <= best_tie_nxt;
            result_none  <= (best_cnt_nxt == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
